// File: rtl/cu_pkg.sv
// Shared definitions for the vector control unit: state encoding, opcodes, widths.
package cu_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

endpackage

// File: rtl/cu_addr_gen.sv
// Address generator: latches base addresses and length, tracks the element
// index and produces base+i addresses that wrap modulo 2^ADDR_W.
module cu_addr_gen #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic              advance,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [ADDR_W-1:0] adr2,
  input  logic [ADDR_W-1:0] dest_adr,
  input  logic [CNT_W-1:0]  len,
  output logic [ADDR_W-1:0] a_adr,
  output logic [ADDR_W-1:0] b_adr,
  output logic [ADDR_W-1:0] w_adr,
  output logic [CNT_W-1:0]  idx,
  output logic              last
);

  logic [ADDR_W-1:0] adr1_q, adr1_d;
  logic [ADDR_W-1:0] adr2_q, adr2_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  i_q, i_d;

  // Capture bases on run start, step the element index after each write.
  always_comb begin
    adr1_d = adr1_q;
    adr2_d = adr2_q;
    dest_d = dest_q;
    len_d  = len_q;
    i_d    = i_q;
    if (latch) begin
      adr1_d = adr1;
      adr2_d = adr2;
      dest_d = dest_adr;
      len_d  = len;
      i_d    = '0;
    end else if (advance) begin
      i_d = i_q + 1'b1;
    end
  end

  // Base, length and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      adr1_q <= '0;
      adr2_q <= '0;
      dest_q <= '0;
      len_q  <= '0;
      i_q    <= '0;
    end else begin
      adr1_q <= adr1_d;
      adr2_q <= adr2_d;
      dest_q <= dest_d;
      len_q  <= len_d;
      i_q    <= i_d;
    end
  end

  // Truncating the sum to ADDR_W gives the wrap-around addressing.
  always_comb begin
    a_adr = ADDR_W'(adr1_q + ADDR_W'(i_q));
    b_adr = ADDR_W'(adr2_q + ADDR_W'(i_q));
    w_adr = ADDR_W'(dest_q + ADDR_W'(i_q));
    idx   = i_q;
    last  = (i_q == len_q - 1'b1);
  end

endmodule

// File: rtl/vec_cu.sv
// Vector control unit: sequences load A / load B / exec / write for each
// element of a vector run, with start/busy/done handshake.
module vec_cu
  import cu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned EXEC_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [ADDR_W-1:0] adr2,
  input  logic [ADDR_W-1:0] dest_adr,
  input  logic [CNT_W-1:0]  len,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_adr,
  output logic              ld_sel,
  output logic              alu_en,
  output logic [1:0]        alu_op,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [CNT_W-1:0]  elem_idx,
  output logic [ST_W-1:0]   st_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned EW = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [EW-1:0]     ecnt_q, ecnt_d;
  logic              latch, advance, last;
  logic [ADDR_W-1:0] a_adr, b_adr, w_adr;
  logic [CNT_W-1:0]  idx;

  assign latch   = (state_q == ST_IDLE) && start;
  assign advance = (state_q == ST_WRITE) && !last;

  cu_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .latch    (latch),
    .advance  (advance),
    .adr1     (adr1),
    .adr2     (adr2),
    .dest_adr (dest_adr),
    .len      (len),
    .a_adr    (a_adr),
    .b_adr    (b_adr),
    .w_adr    (w_adr),
    .idx      (idx),
    .last     (last)
  );

  // Next-state, opcode latch and exec-latency counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = (len == '0) ? ST_DONE : ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        ecnt_d  = EW'(EXEC_CYC - 1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ecnt_q != '0) ecnt_d = ecnt_q - 1'b1;
        else              state_d = ST_WRITE;
      end
      ST_WRITE: state_d = last ? ST_DONE : ST_LOAD_A;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Moore output decode from registered state and latched values.
  always_comb begin
    rf_we    = 1'b0;
    rf_adr   = '0;
    ld_sel   = 1'b0;
    alu_en   = 1'b0;
    alu_op   = '0;
    ram_we   = 1'b0;
    ram_adr  = '0;
    elem_idx = '0;
    busy     = 1'b0;
    done     = 1'b0;
    st_out   = state_q;
    case (state_q)
      ST_LOAD_A: begin
        rf_we = 1'b1; rf_adr = a_adr;
        busy = 1'b1; elem_idx = idx;
      end
      ST_LOAD_B: begin
        rf_we = 1'b1; rf_adr = b_adr; ld_sel = 1'b1;
        busy = 1'b1; elem_idx = idx;
      end
      ST_EXEC: begin
        alu_en = 1'b1; alu_op = op_q;
        busy = 1'b1; elem_idx = idx;
      end
      ST_WRITE: begin
        ram_we = 1'b1; ram_adr = w_adr;
        busy = 1'b1; elem_idx = idx;
      end
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b1; elem_idx = idx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_cu.sv
// Self-checking bench for vec_cu: two instances (EXEC_CYC=1 and 4) share
// stimulus; a per-run output schedule model is compared every cycle.
module tb_vec_cu;

  localparam int AW = 3;
  localparam int CW = 4;

  typedef struct packed {
    logic          rf_we;
    logic [AW-1:0] rf_adr;
    logic          ld_sel;
    logic          alu_en;
    logic [1:0]    alu_op;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [CW-1:0] elem_idx;
    logic [2:0]    st;
    logic          busy;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = '0;
  logic [AW-1:0] adr1 = '0, adr2 = '0, dest_adr = '0;
  logic [CW-1:0] len = '0;

  logic rf_we_1, ld_sel_1, alu_en_1, ram_we_1, busy_1, done_1;
  logic [AW-1:0] rf_adr_1, ram_adr_1;
  logic [1:0] alu_op_1;
  logic [CW-1:0] elem_idx_1;
  logic [2:0] st_out_1;
  logic rf_we_4, ld_sel_4, alu_en_4, ram_we_4, busy_4, done_4;
  logic [AW-1:0] rf_adr_4, ram_adr_4;
  logic [1:0] alu_op_4;
  logic [CW-1:0] elem_idx_4;
  logic [2:0] st_out_4;

  exp_t act1, act4;
  exp_t q1[$], q4[$], scratch[$];
  int compared = 0;
  int failed = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  vec_cu #(.ADDR_W(AW), .CNT_W(CW), .EXEC_CYC(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .adr1(adr1), .adr2(adr2),
    .dest_adr(dest_adr), .len(len), .rf_we(rf_we_1), .rf_adr(rf_adr_1),
    .ld_sel(ld_sel_1), .alu_en(alu_en_1), .alu_op(alu_op_1), .ram_we(ram_we_1),
    .ram_adr(ram_adr_1), .elem_idx(elem_idx_1), .st_out(st_out_1),
    .busy(busy_1), .done(done_1)
  );

  vec_cu #(.ADDR_W(AW), .CNT_W(CW), .EXEC_CYC(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .adr1(adr1), .adr2(adr2),
    .dest_adr(dest_adr), .len(len), .rf_we(rf_we_4), .rf_adr(rf_adr_4),
    .ld_sel(ld_sel_4), .alu_en(alu_en_4), .alu_op(alu_op_4), .ram_we(ram_we_4),
    .ram_adr(ram_adr_4), .elem_idx(elem_idx_4), .st_out(st_out_4),
    .busy(busy_4), .done(done_4)
  );

  assign act1 = {rf_we_1, rf_adr_1, ld_sel_1, alu_en_1, alu_op_1, ram_we_1,
                 ram_adr_1, elem_idx_1, st_out_1, busy_1, done_1};
  assign act4 = {rf_we_4, rf_adr_4, ld_sel_4, alu_en_4, alu_op_4, ram_we_4,
                 ram_adr_4, elem_idx_4, st_out_4, busy_4, done_4};

  // Expected per-cycle outputs of a whole run, starting the cycle after start.
  task automatic build(input int ec, input logic [1:0] o, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] d,
                       input logic [CW-1:0] n);
    exp_t e;
    scratch.delete();
    for (int i = 0; i < int'(n); i++) begin
      e = '0; e.busy = 1'b1; e.elem_idx = CW'(i);
      e.st = 3'd1; e.rf_we = 1'b1; e.rf_adr = AW'((int'(a1) + i) % (1 << AW));
      scratch.push_back(e);
      e.st = 3'd2; e.rf_adr = AW'((int'(a2) + i) % (1 << AW)); e.ld_sel = 1'b1;
      scratch.push_back(e);
      e.rf_we = 1'b0; e.rf_adr = '0; e.ld_sel = 1'b0;
      for (int k = 0; k < ec; k++) begin
        e.st = 3'd3; e.alu_en = 1'b1; e.alu_op = o;
        scratch.push_back(e);
      end
      e.alu_en = 1'b0; e.alu_op = '0;
      e.st = 3'd4; e.ram_we = 1'b1; e.ram_adr = AW'((int'(d) + i) % (1 << AW));
      scratch.push_back(e);
    end
    e = '0; e.st = 3'd5; e.busy = 1'b1; e.done = 1'b1;
    e.elem_idx = (n == '0) ? '0 : CW'(int'(n) - 1);
    scratch.push_back(e);
  endtask

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic pin(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      failed++;
      $display("FAIL pin_%s actual=%0d required=%0d", nm, got, exp);
    end
  endtask

  // Compare process: each cycle check both DUTs, then advance the model.
  initial begin
    exp_t e1, e4;
    bit idle1, idle4;
    forever begin
      @(negedge clk);
      if (armed) begin
        idle1 = (q1.size() == 0);
        idle4 = (q4.size() == 0);
        e1 = idle1 ? exp_t'('0) : q1.pop_front();
        e4 = idle4 ? exp_t'('0) : q4.pop_front();
        check("dut_ec1", act1, e1);
        check("dut_ec4", act4, e4);
        if (reset) begin
          q1.delete();
          q4.delete();
        end else if (start) begin
          if (idle1) begin build(1, op, adr1, adr2, dest_adr, len); q1 = scratch; end
          if (idle4) begin build(4, op, adr1, adr2, dest_adr, len); q4 = scratch; end
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      if (q1.size() == 0 && q4.size() == 0) break;
      @(posedge clk); #2;
    end
    if (k == 300) begin
      compared++;
      failed++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic [AW-1:0] d, input logic [CW-1:0] n);
    start = 1'b1; op = o; adr1 = a1; adr2 = a2; dest_adr = d; len = n;
    @(posedge clk); #2;
    start = 1'b0;
    op = 2'($urandom); adr1 = AW'($urandom); adr2 = AW'($urandom);
    dest_adr = AW'($urandom); len = CW'($urandom);
    wait_idle();
  endtask

  initial begin
    // Pin the model against hand-computed schedules.
    build(1, 2'b00, 3'd1, 3'd4, 3'd2, 4'd1);
    pin("len1_size", scratch.size(), 5);
    pin("len1_a", int'(scratch[0].rf_adr), 1);
    pin("len1_b", int'(scratch[1].rf_adr), 4);
    pin("len1_bsel", int'(scratch[1].ld_sel), 1);
    pin("len1_w", int'(scratch[3].ram_adr), 2);
    pin("len1_done", int'(scratch[4].done), 1);
    build(1, 2'b00, 3'd6, 3'd0, 3'd7, 4'd3);
    pin("wrap_size", scratch.size(), 13);
    pin("wrap_a1", int'(scratch[4].rf_adr), 7);
    pin("wrap_a2", int'(scratch[8].rf_adr), 0);
    pin("wrap_w0", int'(scratch[3].ram_adr), 7);
    pin("wrap_w1", int'(scratch[7].ram_adr), 0);
    pin("wrap_w2", int'(scratch[11].ram_adr), 1);
    pin("wrap_idx", int'(scratch[8].elem_idx), 2);
    build(4, 2'b10, 3'd0, 3'd0, 3'd0, 4'd2);
    pin("ec4_size", scratch.size(), 15);
    pin("ec4_op", int'(scratch[5].alu_op), 2);
    pin("ec4_we", int'(scratch[6].ram_we), 1);
    build(1, 2'b00, 3'd0, 3'd0, 3'd0, 4'd0);
    pin("len0_size", scratch.size(), 1);
    pin("len0_st", int'(scratch[0].st), 5);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 armed = 1'b1;
    @(posedge clk); #2 reset = 1'b0;

    run(2'b00, 3'd1, 3'd4, 3'd2, 4'd1);
    run(2'b00, 3'd6, 3'd0, 3'd7, 4'd3);
    run(2'b10, 3'd3, 3'd5, 3'd1, 4'd2);
    run(2'b01, 3'd2, 3'd2, 3'd2, 4'd0);

    // Reset during the second EXEC of a len=3 run.
    start = 1'b1; op = 2'b01; adr1 = 3'd2; adr2 = 3'd3; dest_adr = 3'd4; len = 4'd3;
    @(posedge clk); #2 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    wait_idle();

    // Start held high through a run; new bases take effect only after DONE.
    start = 1'b1; op = 2'b11; adr1 = 3'd5; adr2 = 3'd1; dest_adr = 3'd6; len = 4'd2;
    @(posedge clk); #2;
    op = 2'b01; adr1 = 3'd7; adr2 = 3'd2; dest_adr = 3'd3; len = 4'd1;
    for (int k = 0; k < 100; k++) begin
      if (q1.size() == 0) break;
      @(posedge clk); #2;
    end
    @(posedge clk); #2 start = 1'b0;
    wait_idle();

    // Randomized traffic, including occasional resets mid-run.
    repeat (600) begin
      start = ($urandom % 4 == 0);
      op = 2'($urandom);
      adr1 = AW'($urandom); adr2 = AW'($urandom); dest_adr = AW'($urandom);
      len = ($urandom % 5 == 0) ? '0 : CW'($urandom_range(1, 6));
      reset = ($urandom % 80 == 0);
      @(posedge clk); #2;
    end
    start = 1'b0; reset = 1'b0;
    wait_idle();
    @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/vec_cu.md
# vec_cu

Parametrised vector control unit that sequences element-wise ALU operations between the register file, the ALU/multiplier and the result RAM. For each of `len` elements it loads operand A from `adr1+i` and operand B from `adr2+i`, runs the ALU for `EXEC_CYC` cycles and writes the result to `dest_adr+i`. It uses a start/busy/done handshake and a per-run opcode. It replaces the fixed single-multiply controller in the datapath top level.

## Interface
- `ADDR_W`, 3, width of the register-file and RAM addresses.
- `CNT_W`, 4, width of `len` and of the element counter; maximum vector length is 2^CNT_W−1.
- `EXEC_CYC`, 1, cycles spent in EXEC (ALU/multiplier latency); must be ≥1.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; wins over every other input.
- `start`  in  1  run request; sampled only in IDLE.
- `op`  in  2  ALU op, latched at start: 00 mul, 01 add, 10 sub, 11 pass A.
- `adr1`, `adr2`, `dest_adr`  in  ADDR_W each  base addresses, latched at start.
- `len`  in  CNT_W  element count, latched at start.
- `rf_we`  out  1  register-file read/load strobe.
- `rf_adr`  out  ADDR_W  register-file address.
- `ld_sel`  out  1  operand-register select: 0 loads A, 1 loads B.
- `alu_en`  out  1  ALU/multiplier enable.
- `alu_op`  out  2  latched opcode; 0 when not in EXEC.
- `ram_we`  out  1  result RAM write enable.
- `ram_adr`  out  ADDR_W  result RAM address.
- `elem_idx`  out  CNT_W  current element index i.
- `st_out`  out  3  state encoding.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States and encodings (`st_out`): IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, WRITE=4, DONE=5. Codes 6 and 7 go to IDLE on the next edge.
- Moore outputs are decoded from registered state, counter and latched values. Every output not listed for a state is 0.
- IDLE: if `start`=1, latch `op`, the three bases and `len`, and clear i. Go to LOAD_A, or to DONE if `len`=0.
- LOAD_A: `rf_we`=1, `rf_adr`=adr1+i, `ld_sel`=0. Go to LOAD_B.
- LOAD_B: `rf_we`=1, `rf_adr`=adr2+i, `ld_sel`=1. Go to EXEC and load the exec counter with EXEC_CYC−1.
- EXEC: `alu_en`=1, `alu_op`=op. Stay in EXEC while the exec counter ≠0, decrementing each cycle; at 0, go to WRITE.
- WRITE: `ram_we`=1, `ram_adr`=dest_adr+i. If i==len−1, go to DONE; otherwise increment i and go to LOAD_A.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in LOAD_A, LOAD_B, EXEC, WRITE and DONE.
- `elem_idx` outputs i in all non-IDLE states.
- Address arithmetic: base+i is truncated to ADDR_W bits, so addresses wrap modulo 2^ADDR_W.
- `start` while `busy` is ignored; it is neither queued nor re-latched. Input changes during a run have no effect.

## Timing
- Reset (synchronous): the edge with `reset`=1 puts the block in IDLE. All outputs are 0, and i, the exec counter and the latched values are cleared.
- Reset during a run aborts it: no further `ram_we`, no `done`.
- `start` sampled at edge T: LOAD_A is active in cycle T+1.
- Each element takes 3+EXEC_CYC cycles.
- With `len`=N≥1, `done` is high in cycle T+1+N·(3+EXEC_CYC).
- With `len`=0, `done` is high in cycle T+1.
- Back-to-back runs: the earliest next `start` is sampled in the cycle after DONE, when the block is back in IDLE.

## Structure
- Shared package `cu_pkg` holds the state enum (3-bit, encodings above), the opcode constants (`OP_MUL`, `OP_ADD`, `OP_SUB`, `OP_PASS`) and the `st_out` width.
- One sub-module: `cu_addr_gen`. It holds the latched bases and the element counter and produces base+i addresses with wrap.
- FSM, exec counter and output decode live in `vec_cu`.

## Test plan
- Defaults, `op`=00, `adr1`=1, `adr2`=4, `dest_adr`=2, `len`=1, start pulse → `rf_adr` 1 then 4 with `ld_sel` 0/1, one EXEC cycle with `alu_op`=00, `ram_we` at address 2, `done` 5 cycles after start.
- `len`=3, `adr1`=6, `dest_adr`=7 → A addresses 6,7,0 and RAM addresses 7,0,1 (wrap); `elem_idx` 0,1,2; exactly 3 `ram_we` pulses; `done` 13 cycles after start.
- EXEC_CYC=4, `len`=2, `op`=10 → `alu_en` high for 4 consecutive cycles per element with `alu_op`=10; `done` 15 cycles after start.
- `len`=0 → DONE in the next cycle, `done` pulses once, no `rf_we` or `ram_we`.
- `reset` asserted during the second EXEC of a `len`=3 run → IDLE on the next edge, all outputs 0, no further `ram_we`, no `done`.
- `start` held high for an entire run → no effect while busy; a new run begins one cycle after DONE with the new bases latched.
